// File: rtl/gcd_share_arbiter.sv
// gcd_share_arbiter: one shared iterative single-digit GCD/normalise engine
// serving NREQ requesters. The requester pulls a grant, its operand pair
// (reduced mod 10) is captured in the grant cycle, and a divisor scan from 9
// downward finds the gcd at one candidate per cycle.
// Build option: define GCD_FIXED_PRIO_EN for fixed priority (lowest index
// wins); the default build is round-robin.
module gcd_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   a_in,
    input  logic [4*NREQ-1:0]   b_in,
    output logic [NREQ-1:0]     grant,
    output logic                busy,
    output logic                done,
    output logic [IDW-1:0]      done_id,
    output logic [3:0]          gcd_out,
    output logic [3:0]          qa_out,
    output logic [3:0]          qb_out
);

    localparam int unsigned DW = 4;
    localparam int unsigned SW = IDW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  cur_id;
    logic [DW-1:0]   a_q;
    logic [DW-1:0]   b_q;
    logic [DW-1:0]   j;

    logic [IDW-1:0]  win;
    logic            win_vld;
    logic [SW-1:0]   k_sum;
    logic [IDW-1:0]  k_idx;
    logic [DW-1:0]   a_sel;
    logic [DW-1:0]   b_sel;
    logic            a_div;
    logic            b_div;

    // Winner: first set req bit at or after ptr, searching upward with wrap
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        k_sum   = '0;
        k_idx   = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            k_sum = {1'b0, ptr} + SW'(i);
            if (k_sum >= SW'(NREQ)) begin
                k_sum = k_sum - SW'(NREQ);
            end
            k_idx = IDW'(k_sum);
            if (!win_vld && req[k_idx]) begin
                win_vld = 1'b1;
                win     = k_idx;
            end
        end
    end

    // Operand mux for the requester currently being served
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (cur_id == IDW'(i)) begin
                a_sel = a_in[4*i +: 4];
                b_sel = b_in[4*i +: 4];
            end
        end
    end

    // Divisibility of both captured operands by the current candidate
    always_comb begin
        a_div = 1'b0;
        b_div = 1'b0;
        if (j != '0) begin
            a_div = ((a_q % j) == '0);
            b_div = ((b_q % j) == '0);
        end
    end

    // Arbitration, capture, scan and result sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ptr     <= '0;
            cur_id  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            j       <= '0;
            grant   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            gcd_out <= '0;
            qa_out  <= '0;
            qb_out  <= '0;
        end else begin
            grant <= '0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        grant  <= NREQ'(1) << win;
                        cur_id <= win;
                        busy   <= 1'b1;
                        j      <= DW'(9);
                        state  <= SCAN;
`ifdef GCD_FIXED_PRIO_EN
                        ptr    <= '0;
`else
                        ptr    <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
`endif
                    end
                end
                SCAN: begin
                    if (|grant) begin
                        // grant cycle: operands are valid now, fold into digit domain
                        a_q <= a_sel % DW'(10);
                        b_q <= b_sel % DW'(10);
                    end else if (a_q == '0 && b_q == '0) begin
                        done    <= 1'b1;
                        done_id <= cur_id;
                        gcd_out <= '0;
                        qa_out  <= '0;
                        qb_out  <= '0;
                        state   <= DONE;
                    end else if (a_div && b_div) begin
                        done    <= 1'b1;
                        done_id <= cur_id;
                        gcd_out <= j;
                        qa_out  <= a_q / j;
                        qb_out  <= b_q / j;
                        state   <= DONE;
                    end else begin
                        j <= j - DW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_share_arbiter.sv
// Directed bench for gcd_share_arbiter; expected values computed by hand.
module tb_gcd_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NREQ-1:0]     req;
    logic [4*NREQ-1:0]   a_in;
    logic [4*NREQ-1:0]   b_in;
    logic [NREQ-1:0]     grant;
    logic                busy;
    logic                done;
    logic [IDW-1:0]      done_id;
    logic [3:0]          gcd_out;
    logic [3:0]          qa_out;
    logic [3:0]          qb_out;

    int n_vec;
    int n_err;

    gcd_share_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .gcd_out (gcd_out),
        .qa_out  (qa_out),
        .qb_out  (qb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait (bounded) for a grant pulse; leaves the bench at the grant-cycle negedge
    task automatic wait_grant();
        for (int c = 0; c < 40 && grant == '0; c++) @(negedge clk);
    endtask

    // Wait (bounded) for done; cyc counts cycles since the grant cycle
    task automatic wait_done(inout int cyc);
        while (done == 1'b0 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One full job for requester id, checking grant, latency and results
    task automatic run_job(input string tag, input int id, input logic [3:0] a, input logic [3:0] b,
                           input int eg, input int eqa, input int eqb, input int elat);
        int cyc;
        req[id] = 1'b1;
        a_in[4*id +: 4] = a;
        b_in[4*id +: 4] = b;
        wait_grant();
        check({tag, "_grant"}, 32'(grant), 32'(1 << id));
        check({tag, "_busy_g"}, 32'(busy), 32'd1);
        @(negedge clk);
        req[id] = 1'b0;
        cyc = 1;
        wait_done(cyc);
        check({tag, "_latency"}, 32'(cyc), 32'(elat));
        check({tag, "_id"}, 32'(done_id), 32'(id));
        check({tag, "_gcd"}, 32'(gcd_out), 32'(eg));
        check({tag, "_qa"}, 32'(qa_out), 32'(eqa));
        check({tag, "_qb"}, 32'(qb_out), 32'(eqb));
        check({tag, "_busy_d"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({tag, "_done_off"}, 32'({done, busy}), 32'd0);
        check({tag, "_hold_gcd"}, 32'(gcd_out), 32'(eg));
    endtask

    initial begin
        int cyc;
        int e;
        int ngr;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = '0;
        a_in  = '0;
        b_in  = '0;
        @(negedge clk);
        #1;
        check("reset_outs", 32'({grant, busy, done, done_id, gcd_out, qa_out, qb_out}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_job("t1_6_9", 0, 4'd6, 4'd9, 3, 2, 3, 8);
        run_job("t2_0_0", 0, 4'd0, 4'd0, 0, 0, 0, 2);
        run_job("t3_14_8", 2, 4'd14, 4'd8, 4, 1, 2, 7);
        run_job("t4_0_6", 1, 4'd0, 4'd6, 6, 0, 1, 5);
        run_job("t5_7_5", 0, 4'd7, 4'd5, 1, 7, 5, 10);
        run_job("t6_12_9", 3, 4'd12, 4'd9, 1, 2, 9, 10);

        // All four requesting: round-robin order from a reset pointer
        do_reset();
        a_in = {4'd8, 4'd6, 4'd4, 4'd2};
        b_in = {4'd4, 4'd3, 4'd2, 4'd1};
        req  = 4'hF;
        for (int n = 0; n < 4; n++) begin
`ifdef GCD_FIXED_PRIO_EN
            e = 0;
`else
            e = n;
`endif
            wait_grant();
            check("all_grant", 32'(grant), 32'(1 << e));
            @(negedge clk);
            req[e] = 1'b0;
            cyc = 1;
            wait_done(cyc);
            check("all_id", 32'(done_id), 32'(e));
            @(negedge clk);
            if (n < 3) begin
`ifdef GCD_FIXED_PRIO_EN
                req[0] = 1'b1;
`endif
            end else begin
                req = '0;
            end
        end

        // Reset during SCAN aborts the job
        req[1] = 1'b1;
        a_in[7:4] = 4'd7;
        b_in[7:4] = 4'd5;
        wait_grant();
        check("abort_grant", 32'(grant), 32'h2);
        @(negedge clk);
        req[1] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outs", 32'({grant, busy, done, done_id, gcd_out, qa_out, qb_out}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ngr = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) ngr++;
        end
        check("abort_no_done", 32'(ngr), 32'd0);
        run_job("t7_after_rst", 3, 4'd2, 4'd4, 2, 1, 2, 9);

        // req1 withdrawn before arbitration while req3 waits
        req[0] = 1'b1;
        a_in[3:0] = 4'd6;
        b_in[3:0] = 4'd9;
        wait_grant();
        check("drop_g0", 32'(grant), 32'h1);
        @(negedge clk);
        req[0] = 1'b0;
        req[1] = 1'b1;
        req[3] = 1'b1;
        a_in[15:12] = 4'd8;
        b_in[15:12] = 4'd4;
        cyc = 1;
        wait_done(cyc);
        check("drop_d0", 32'(done_id), 32'd0);
        req[1] = 1'b0;
        wait_grant();
        check("drop_grant", 32'(grant), 32'h8);
        @(negedge clk);
        req[3] = 1'b0;
        cyc = 1;
        wait_done(cyc);
        check("drop_lat", 32'(cyc), 32'd7);
        check("drop_id", 32'(done_id), 32'd3);
        check("drop_res", 32'({gcd_out, qa_out, qb_out}), 32'h421);
        ngr = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (grant != '0 || done) ngr++;
        end
        check("drop_no_serve", 32'(ngr), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_share_arbiter.md
Name: gcd_share_arbiter

Overview:
Shares one iterative single-digit GCD/normalise engine between NREQ requesters, such as several two-digit buffer/display units.
- Arbitrates requests and captures the winner's operand pair.
- Sequences a one-candidate-per-cycle divisor scan.
- Returns gcd and both reduced quotients, tagged with the requester id.
- Replaces per-unit combinational GCD logic with one shared multi-cycle resource.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, width of requester id (must be >= clog2(NREQ))

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
req  input  NREQ  per-requester request level; held until granted
a_in  input  4*NREQ  operand A of requester k at bits [4k+3:4k]
b_in  input  4*NREQ  operand B of requester k at bits [4k+3:4k]
grant  output  NREQ  one-hot, 1-cycle pulse; operands captured that cycle
busy  output  1  high from grant cycle through done cycle
done  output  1  1-cycle pulse; results valid
done_id  output  IDW  id of requester served by this result
gcd_out  output  4  greatest common divisor (1..9, or 0 for 0/0)
qa_out  output  4  captured A / gcd_out
qb_out  output  4  captured B / gcd_out

Behaviour:
- Reset: all outputs 0; FSM to IDLE; round-robin pointer to 0; operand/scan registers 0.
- Reset asserted mid-operation aborts the job; no done is produced for it.
- Operand capture: each operand is reduced mod 10 (digit domain), so 4'd12 captures as 2.
- FSM states: IDLE, SCAN, DONE.
- IDLE, no req bit set: stay in IDLE.
- IDLE, any req bit set: pick the winner.
  - Winner is the first set bit at or after the pointer, searching upward with wrap.
  - Pulse grant[winner], capture its operands, set busy, set j=9, go to SCAN.
  - Pointer becomes winner+1, wrapping to 0 after NREQ-1.
- SCAN, one candidate j per cycle:
  - If A%j==0 and B%j==0, latch gcd=j and go to DONE.
  - Otherwise j=j-1.
  - j=1 always matches, so the scan never underflows.
  - Scan length is (10-gcd) cycles.
- SCAN, special case A==0 and B==0: first SCAN cycle goes straight to DONE with gcd=0, qa=0, qb=0.
- SCAN, other zero operand: the scan runs normally, e.g. A=0, B=6 gives gcd 6, qa 0, qb 1.
- DONE, for one cycle:
  - Pulse done; drive done_id, gcd_out, qa_out=A/gcd, qb_out=B/gcd.
  - Go to IDLE. busy drops in the following IDLE cycle.
- Result outputs hold their values until the next done. grant and done are 0 outside their pulse cycles.
- Latency from the grant cycle to the done cycle is (10-gcd)+1 cycles, or 2 cycles for the 0/0 case.
- A new grant can occur in the cycle after DONE at the earliest; there is no back-to-back overlap.
- Requests:
  - req bits that drop before being granted are not served.
  - req is not sampled while busy.
  - A requester must deassert req in the cycle after its grant, otherwise it is re-arbitrated as a new request.
- Simultaneous requests: exactly one grant per arbitration; losers remain pending. With all NREQ requesting continuously, every requester is served within NREQ jobs.
- Arithmetic: all values are 4-bit unsigned; quotients are exact (no remainder); division by zero is never performed (0/0 is handled by the special case).

Optional Feature:
GCD_FIXED_PRIO_EN
- Defined: fixed priority, lowest index wins; the pointer is unused and held at 0.
- Undefined (default): round-robin as described above.

Test Plan:
- Reset then req=0001, a0=6, b0=9 -> grant=0001 at cycle 1; done 8 cycles later (scan 9..3 = 7 cycles + DONE); done_id=0, gcd=3, qa=2, qb=3.
- req0 with a=0, b=0 -> done 2 cycles after grant; gcd=0, qa=0, qb=0.
- req2 with a=4'd14, b=8 -> captured A=4; gcd=4, qa=1, qb=2, done_id=2; scan length 6 cycles.
- All four req held high, each served and then dropped -> grant order 0,1,2,3 (round-robin); with GCD_FIXED_PRIO_EN and req re-raised after service, requester 0 is granted every time.
- req1, a=7, b=5, rst_n low during SCAN -> all outputs 0 immediately; no done; after release, a new req3 is granted first (pointer reset to 0, no other req pending).
- req1 drops one cycle before arbitration while req3 is high -> grant=1000 only; requester 1 gets no done.
